// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the four-requester round-robin packet arbiter.
package mux4_arb_pkg;

    // Arbiter control states: waiting for a request, or owned by one requester.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int NUM_REQ   = 4;
    localparam int SEL_W     = 2;
    localparam int DEFAULT_W = 8;

endpackage

// File: rtl/mux4_w.sv
// W-bit 4:1 multiplexer built as a tree of 2:1 selects, one slice per bit.
module mux4_w #(
    parameter int W = 8
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [1:0]   sel,
    output logic [W-1:0] y
);

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            logic lo;
            logic hi;
            // First rank picks within each pair on s0, second rank picks the pair on s1.
            assign lo    = sel[0] ? in1[gi] : in0[gi];
            assign hi    = sel[0] ? in3[gi] : in2[gi];
            assign y[gi] = sel[1] ? hi : lo;
        end
    endgenerate

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: returns the first set request bit found
// when scanning ptr, ptr+1, ... modulo 4.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    // Requests rotated so that bit 0 is the current highest-priority requester.
    logic [NUM_REQ-1:0] rot;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign rot[gi] = req[ptr + SEL_W'(gi)];
        end
    endgenerate

    // Lowest set bit of the rotated vector wins; translate back to an absolute index.
    always_comb begin
        found = |rot;
        idx   = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = ptr + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin packet arbiter driving the select of a shared 4:1 data mux.
// A grant is held from the first beat until the owner's last beat is
// accepted downstream; priority then rotates to the next requester.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic [W-1:0]       in0,
    input  logic [W-1:0]       in1,
    input  logic [W-1:0]       in2,
    input  logic [W-1:0]       in3,
    output logic [NUM_REQ-1:0] in_ready,
    output logic [W-1:0]       out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] grant
);

    state_t             state_reg;
    logic [SEL_W-1:0]   sel_reg;
    logic [SEL_W-1:0]   ptr_reg;
    logic [NUM_REQ-1:0] grant_reg;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               busy;
    logic               xfer;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Data path is purely combinational from the inputs; only the select is registered.
    mux4_w #(.W(W)) u_mux (
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .sel (sel_reg),
        .y   (out_data)
    );

    assign busy  = (state_reg == BUSY);
    assign sel   = sel_reg;
    assign grant = grant_reg;
    assign xfer  = out_valid & out_ready;

    // Handshake outputs follow the owner's request; non-owners never see ready.
    always_comb begin
        out_valid = busy & req[sel_reg];
        out_last  = out_valid & last[sel_reg];
        in_ready  = '0;
        if (busy) begin
            in_ready[sel_reg] = out_ready;
        end
    end

    // Arbitration FSM: grant on any request in IDLE, release after the last beat transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            ptr_reg   <= '0;
            grant_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        sel_reg   <= pick_idx;
                        grant_reg <= NUM_REQ'(1) << pick_idx;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    // Owner dropping req or downstream stalling simply holds the grant.
                    if (xfer && out_last) begin
                        ptr_reg   <= sel_reg + SEL_W'(1);
                        grant_reg <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= '0;
                end
            endcase
        end
    end

endmodule
